// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// fills the IF/ID pipeline register. Handles stall, flush and branch/jump redirects.
//
// Optional feature: define IF_PERF_CNT_EN to add saturating performance counters
// (fetch_count, stall_count, redirect_count). Without it, those ports do not exist.

module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned PC_INC    = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_next,
    output logic        misalign
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [31:0] redirect_count
`endif
);

    // PC_INC is a power of two, so the low log2(PC_INC) bits are exactly PC_INC-1.
    localparam logic [31:0] PcStep    = 32'(PC_INC);
    localparam logic [31:0] AlignMask = 32'(PC_INC - 1);

    logic [31:0] pc_q, pc_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc_next_q, if_id_pc_next_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_seq;
    logic        bubble;
    logic        load;

    // Redirect selection: branch is the older instruction so it beats a jump.
    always_comb begin
        redirect        = branch_taken | jump;
        redirect_target = branch_taken ? branch_target : jump_target;
        pc_seq          = pc_q + PcStep;
        bubble          = flush | redirect;
        load            = ~bubble & ~stall;
    end

    // Next PC and misalign flag.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (redirect) begin
            pc_d       = redirect_target & ~AlignMask;
            misalign_d = |(redirect_target & AlignMask);
        end else if (!stall) begin
            pc_d = pc_seq;
        end
    end

    // IF/ID next state: bubble keeps the old pc fields, stall keeps everything.
    always_comb begin
        if_id_valid_d   = if_id_valid_q;
        if_id_instr_d   = if_id_instr_q;
        if_id_pc_d      = if_id_pc_q;
        if_id_pc_next_d = if_id_pc_next_q;
        if (bubble) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (load) begin
            if_id_valid_d   = 1'b1;
            if_id_instr_d   = im_data;
            if_id_pc_d      = pc_q;
            if_id_pc_next_d = pc_seq;
        end
    end

    // PC, IF/ID and misalign registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            if_id_valid_q   <= 1'b0;
            if_id_instr_q   <= NOP_INSTR;
            if_id_pc_q      <= 32'h0;
            if_id_pc_next_q <= 32'h0;
            misalign_q      <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            if_id_valid_q   <= if_id_valid_d;
            if_id_instr_q   <= if_id_instr_d;
            if_id_pc_q      <= if_id_pc_d;
            if_id_pc_next_q <= if_id_pc_next_d;
            misalign_q      <= misalign_d;
        end
    end

    assign im_addr       = pc_q;
    assign if_id_valid   = if_id_valid_q;
    assign if_id_instr   = if_id_instr_q;
    assign if_id_pc      = if_id_pc_q;
    assign if_id_pc_next = if_id_pc_next_q;
    assign misalign      = misalign_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'h1 : v;
    endfunction

    // Counter next state; stalls only count when no redirect overrides them.
    always_comb begin
        fetch_cnt_d    = sat_inc(fetch_cnt_q, load);
        stall_cnt_d    = sat_inc(stall_cnt_q, stall & ~redirect);
        redirect_cnt_d = sat_inc(redirect_cnt_q, redirect);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q    <= 32'h0;
            stall_cnt_q    <= 32'h0;
            redirect_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign fetch_count    = fetch_cnt_q;
    assign stall_count    = stall_cnt_q;
    assign redirect_count = redirect_cnt_q;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the processor pipeline. Sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory address. The memory returns the instruction combinationally in the same cycle.
- Captures the instruction, its PC and its fall-through PC into the IF/ID pipeline register for the decode stage.
- Handles stall, flush and branch/jump redirects coming back from the decode and execute stages.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- PC_INC, 8: byte stride between consecutive instructions. Must be a power of two, at least 4. Matches the memory's word indexing.
- NOP_INSTR, 32'h0000_0000: instruction word held in IF/ID when the register contains a bubble.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents (load-use hazard from decode).
- flush  input  1  turn the IF/ID entry into a bubble on this edge.
- branch_taken  input  1  execute stage resolved a taken branch.
- branch_target  input  32  byte address of the branch target.
- jump  input  1  decode stage found an unconditional jump.
- jump_target  input  32  byte address of the jump target.
- im_addr  output  32  byte address to the instruction memory; equals pc.
- im_data  input  32  instruction word returned by the memory in the same cycle.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_instr  output  32  fetched instruction, or NOP_INSTR when a bubble.
- if_id_pc  output  32  PC of if_id_instr.
- if_id_pc_next  output  32  if_id_pc + PC_INC.
- misalign  output  1  registered one-cycle pulse: the last redirect target had nonzero bits below log2(PC_INC).

Behaviour:
- Reset (rst=1 at the edge):
  - pc <= RESET_PC.
  - if_id_valid <= 0, if_id_instr <= NOP_INSTR, if_id_pc <= 0, if_id_pc_next <= 0, misalign <= 0.
  - rst overrides every other input.
- im_addr = pc, combinational. No extra latency is added: the instruction fetched at pc appears in IF/ID one edge later.
- Next-PC priority (highest first): rst > branch_taken > jump > stall > sequential.
  - branch_taken: pc <= branch_target with bits [log2(PC_INC)-1:0] forced to 0. Branch wins over a simultaneous jump, because the branch is the older instruction.
  - jump: pc <= jump_target with the same alignment masking.
  - stall (no redirect): pc holds.
  - otherwise: pc <= pc + PC_INC, modulo 2^32. Wrap at 32'hFFFF_FFF8 to 0 is silent.
- misalign <= 1 for exactly one cycle when the accepted redirect target had any masked bit set; 0 otherwise.
- IF/ID update priority (highest first): rst > (flush | branch_taken | jump) > stall > load.
  - Bubble: valid <= 0, instr <= NOP_INSTR. pc and pc_next fields hold their previous values.
  - stall: all IF/ID fields hold, including valid.
  - load: valid <= 1, instr <= im_data, pc <= current pc, pc_next <= pc + PC_INC.
- Simultaneous stall + redirect: the redirect is taken and IF/ID becomes a bubble. The stall is ignored for this stage.
- Simultaneous stall + flush without redirect: pc holds and IF/ID becomes a bubble.
- First cycle after reset is released: IF/ID is already invalid. The edge at the end of that cycle loads the instruction at RESET_PC (valid = 1), unless stall or flush is asserted.
- Reset asserted mid-stall or mid-redirect: reset wins on that edge. No pending redirect survives reset.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds three output ports, each 32 bits, cleared by rst and saturating at 32'hFFFF_FFFF.
  - fetch_count: increments on each edge where IF/ID loads a valid instruction.
  - stall_count: increments on each edge where stall=1 and no redirect is taken.
  - redirect_count: increments on each accepted branch_taken or jump.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then 4 free-running cycles, im_data = 0x100 + pc -> im_addr sequence 0, 8, 16, 24. IF/ID shows (pc=0, instr=0x100), then (8, 0x108), (16, 0x110). if_id_pc_next = if_id_pc + 8. valid = 1 from the second edge.
- stall=1 for 2 cycles at pc=16 -> im_addr stays 16 and IF/ID holds (8, 0x108, valid=1). Resumes at 24 after release.
- branch_taken=1 with branch_target=0x40 while jump=1 with jump_target=0x80 -> next pc = 0x40, IF/ID bubble (valid=0, instr=NOP). Next edge loads pc=0x40.
- jump_target=0x2C -> pc = 0x28 and misalign pulses to 1 for one cycle.
- stall=1 and flush=1 together at pc=24 -> pc holds 24 and valid=0. Removing both loads pc=24.
- With IF_PERF_CNT_EN: 10 loads, 3 stalls, 2 redirects, then rst -> counts read 10/3/2, all 0 after reset. Counter preset near max saturates at 0xFFFF_FFFF.
